// File: rtl/eth_ip_udp_tx_hdr_insert_pkg.sv
// Shared Ethernet/IPv4/UDP header layouts and constants for the TX framing path.
package eth_ip_udp_tx_hdr_insert_pkg;

    localparam int          DATA_W                   = 64;
    localparam logic [15:0] ETH_TYPE_IPV4            = 16'h0800;
    localparam logic [7:0]  IP_PROTO_UDP             = 8'd17;
    localparam int          IPV4_UDP_FRAME_HDR_BYTES = 42;
    localparam int          HDR_W                    = IPV4_UDP_FRAME_HDR_BYTES * 8;

    typedef struct packed {
        logic [47:0] dst_mac;
        logic [47:0] src_mac;
        logic [15:0] eth_type;
    } eth_hdr_t;

    typedef struct packed {
        logic [3:0]  ver;
        logic [3:0]  ihl;
        logic [7:0]  tos;
        logic [15:0] tot_len;
        logic [15:0] id;
        logic [15:0] frag;
        logic [7:0]  ttl;
        logic [7:0]  proto;
        logic [15:0] chksum;
        logic [31:0] src_ip;
        logic [31:0] dst_ip;
    } ip_pkt_hdr_t;

    typedef struct packed {
        logic [15:0] src_port;
        logic [15:0] dst_port;
        logic [15:0] length;
        logic [15:0] chksum;
    } udp_pkt_hdr_t;

    typedef struct packed {
        logic [47:0] dst_mac;
        logic [47:0] src_mac;
        logic [31:0] src_ip;
        logic [31:0] dst_ip;
        logic [15:0] src_port;
        logic [15:0] dst_port;
        logic [15:0] data_len;
        logic [15:0] id;
    } tx_meta_t;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CHKSUM,
        S_HDR,
        S_MERGE,
        S_PAYLOAD,
        S_FLUSH
    } tx_state_e;

endpackage

// File: rtl/ip_hdr_chksum_gen.sv
// Combinational IPv4 header checksum; the incoming chksum field is ignored (treated as zero).
module ip_hdr_chksum_gen
    import eth_ip_udp_tx_hdr_insert_pkg::*;
(
    input  ip_pkt_hdr_t ip_hdr_i,
    output logic [15:0] chksum_o
);

    ip_pkt_hdr_t  hdr_zc;
    logic [159:0] hdr_bits;
    logic [19:0]  sum;
    logic [16:0]  fold1;

    always_comb begin
        hdr_zc        = ip_hdr_i;
        hdr_zc.chksum = 16'h0;
        hdr_bits      = hdr_zc;
        sum           = '0;
        for (int i = 0; i < 10; i++) begin
            sum = sum + {4'h0, hdr_bits[159-16*i -: 16]};
        end
        // Ten 16-bit words fit in 20 bits; two folds always absorb the carry.
        fold1    = {1'b0, sum[15:0]} + {13'h0, sum[19:16]};
        chksum_o = ~(fold1[15:0] + {15'h0, fold1[16]});
    end

endmodule

// File: rtl/eth_ip_udp_tx_hdr_insert.sv
// TX framer: prepends a 42-byte Ethernet/IPv4/UDP header to a 64-bit payload stream.
//  state   | meaning
//  IDLE    | waiting for packet metadata
//  CHKSUM  | IPv4 header checksum is computed and registered
//  HDR     | header words 0..4 (bytes 0..39) emitted
//  MERGE   | last 2 header bytes joined with the first payload word
//  PAYLOAD | payload shifted by 2 bytes through the carry register
//  FLUSH   | trailing carry bytes emitted as the final word
module eth_ip_udp_tx_hdr_insert
    import eth_ip_udp_tx_hdr_insert_pkg::*;
#(
    parameter logic [7:0]  IP_TTL     = 8'd64,
    parameter logic [15:0] IP_ID_INIT = 16'd0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              src_meta_val,
    input  logic [47:0]       src_meta_src_mac,
    input  logic [47:0]       src_meta_dst_mac,
    input  logic [31:0]       src_meta_src_ip,
    input  logic [31:0]       src_meta_dst_ip,
    input  logic [15:0]       src_meta_src_port,
    input  logic [15:0]       src_meta_dst_port,
    input  logic [15:0]       src_meta_data_len,
    output logic              src_meta_rdy,
    input  logic              src_data_val,
    input  logic [DATA_W-1:0] src_data,
    input  logic              src_data_last,
    input  logic [2:0]        src_data_padbytes,
    output logic              src_data_rdy,
    output logic              dst_val,
    output logic [DATA_W-1:0] dst_data,
    output logic              dst_last,
    output logic [2:0]        dst_padbytes,
    input  logic              dst_rdy
);

    tx_state_e   state_q, state_d;
    tx_meta_t    meta_q, meta_d;
    logic [15:0] id_q, id_d;
    logic [15:0] chksum_q, chksum_d;
    logic [2:0]  word_cnt_q, word_cnt_d;
    logic [15:0] carry_q, carry_d;
    logic [2:0]  pad_q, pad_d;

    eth_hdr_t         eth_hdr;
    ip_pkt_hdr_t      ip_hdr;
    udp_pkt_hdr_t     udp_hdr;
    logic [HDR_W-1:0] hdr_vec;
    logic [4:0][63:0] hdr_words;
    logic [15:0]      chksum_calc;
    logic [15:0]      front;

    always_comb begin
        eth_hdr.dst_mac  = meta_q.dst_mac;
        eth_hdr.src_mac  = meta_q.src_mac;
        eth_hdr.eth_type = ETH_TYPE_IPV4;
        ip_hdr.ver       = 4'd4;
        ip_hdr.ihl       = 4'd5;
        ip_hdr.tos       = 8'd0;
        ip_hdr.tot_len   = 16'd28 + meta_q.data_len;
        ip_hdr.id        = meta_q.id;
        ip_hdr.frag      = 16'h4000;
        ip_hdr.ttl       = IP_TTL;
        ip_hdr.proto     = IP_PROTO_UDP;
        ip_hdr.chksum    = chksum_q;
        ip_hdr.src_ip    = meta_q.src_ip;
        ip_hdr.dst_ip    = meta_q.dst_ip;
        udp_hdr.src_port = meta_q.src_port;
        udp_hdr.dst_port = meta_q.dst_port;
        udp_hdr.length   = 16'd8 + meta_q.data_len;
        udp_hdr.chksum   = 16'h0;
        hdr_vec          = {eth_hdr, ip_hdr, udp_hdr};
        hdr_words        = hdr_vec[HDR_W-1:16];
    end

    ip_hdr_chksum_gen u_chksum (
        .ip_hdr_i (ip_hdr),
        .chksum_o (chksum_calc)
    );

    always_comb begin
        state_d      = state_q;
        meta_d       = meta_q;
        id_d         = id_q;
        chksum_d     = chksum_q;
        word_cnt_d   = word_cnt_q;
        carry_d      = carry_q;
        pad_d        = pad_q;
        src_meta_rdy = 1'b0;
        src_data_rdy = 1'b0;
        dst_val      = 1'b0;
        dst_data     = '0;
        dst_last     = 1'b0;
        dst_padbytes = 3'd0;
        front        = (state_q == S_MERGE) ? hdr_vec[15:0] : carry_q;

        case (state_q)
            S_IDLE: begin
                src_meta_rdy = 1'b1;
                if (src_meta_val) begin
                    meta_d.dst_mac  = src_meta_dst_mac;
                    meta_d.src_mac  = src_meta_src_mac;
                    meta_d.src_ip   = src_meta_src_ip;
                    meta_d.dst_ip   = src_meta_dst_ip;
                    meta_d.src_port = src_meta_src_port;
                    meta_d.dst_port = src_meta_dst_port;
                    meta_d.data_len = src_meta_data_len;
                    meta_d.id       = id_q;
                    id_d            = id_q + 16'd1;
                    state_d         = S_CHKSUM;
                end
            end
            S_CHKSUM: begin
                chksum_d   = chksum_calc;
                word_cnt_d = 3'd0;
                state_d    = S_HDR;
            end
            S_HDR: begin
                dst_val  = 1'b1;
                dst_data = hdr_words[3'd4 - word_cnt_q];
                if (dst_rdy) begin
                    if (word_cnt_q == 3'd4) state_d = S_MERGE;
                    else                    word_cnt_d = word_cnt_q + 3'd1;
                end
            end
            S_MERGE, S_PAYLOAD: begin
                if (state_q == S_MERGE && meta_q.data_len == 16'd0) begin
                    dst_val      = 1'b1;
                    dst_data     = {hdr_vec[15:0], 48'h0};
                    dst_last     = 1'b1;
                    dst_padbytes = 3'd6;
                    if (dst_rdy) state_d = S_IDLE;
                end else begin
                    dst_val      = src_data_val;
                    src_data_rdy = dst_rdy;
                    dst_data     = {front, src_data[63:16]};
                    if (src_data_last && src_data_padbytes >= 3'd2) begin
                        dst_last     = 1'b1;
                        dst_padbytes = src_data_padbytes - 3'd2;
                    end
                    if (src_data_val && dst_rdy) begin
                        carry_d = src_data[15:0];
                        if (!src_data_last)                 state_d = S_PAYLOAD;
                        else if (src_data_padbytes >= 3'd2) state_d = S_IDLE;
                        else begin
                            pad_d   = src_data_padbytes;
                            state_d = S_FLUSH;
                        end
                    end
                end
            end
            S_FLUSH: begin
                dst_val      = 1'b1;
                dst_data     = {carry_q, 48'h0};
                dst_last     = 1'b1;
                dst_padbytes = 3'd6 + pad_q;
                if (dst_rdy) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        // Handshakes are held off during the reset cycle itself.
        if (rst) begin
            src_meta_rdy = 1'b0;
            src_data_rdy = 1'b0;
            dst_val      = 1'b0;
            dst_last     = 1'b0;
            dst_padbytes = 3'd0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            meta_q     <= '0;
            id_q       <= IP_ID_INIT;
            chksum_q   <= '0;
            word_cnt_q <= '0;
            carry_q    <= '0;
            pad_q      <= '0;
        end else begin
            state_q    <= state_d;
            meta_q     <= meta_d;
            id_q       <= id_d;
            chksum_q   <= chksum_d;
            word_cnt_q <= word_cnt_d;
            carry_q    <= carry_d;
            pad_q      <= pad_d;
        end
    end

endmodule

// File: tb/tb_eth_ip_udp_tx_hdr_insert.sv
// Bench for the UDP TX framer: byte-level frame model, scoreboard monitor, directed packets.
module tb_eth_ip_udp_tx_hdr_insert;

    localparam logic [7:0]  TTL     = 8'd64;
    localparam logic [15:0] ID_INIT = 16'd0;

    logic        clk = 1'b0;
    logic        rst;
    logic        src_meta_val;
    logic [47:0] src_meta_src_mac, src_meta_dst_mac;
    logic [31:0] src_meta_src_ip, src_meta_dst_ip;
    logic [15:0] src_meta_src_port, src_meta_dst_port, src_meta_data_len;
    logic        src_meta_rdy;
    logic        src_data_val;
    logic [63:0] src_data;
    logic        src_data_last;
    logic [2:0]  src_data_padbytes;
    logic        src_data_rdy;
    logic        dst_val;
    logic [63:0] dst_data;
    logic        dst_last;
    logic [2:0]  dst_padbytes;
    logic        dst_rdy;

    always #5 clk = ~clk;

    eth_ip_udp_tx_hdr_insert #(.IP_TTL(TTL), .IP_ID_INIT(ID_INIT)) dut (
        .clk               (clk),
        .rst               (rst),
        .src_meta_val      (src_meta_val),
        .src_meta_src_mac  (src_meta_src_mac),
        .src_meta_dst_mac  (src_meta_dst_mac),
        .src_meta_src_ip   (src_meta_src_ip),
        .src_meta_dst_ip   (src_meta_dst_ip),
        .src_meta_src_port (src_meta_src_port),
        .src_meta_dst_port (src_meta_dst_port),
        .src_meta_data_len (src_meta_data_len),
        .src_meta_rdy      (src_meta_rdy),
        .src_data_val      (src_data_val),
        .src_data          (src_data),
        .src_data_last     (src_data_last),
        .src_data_padbytes (src_data_padbytes),
        .src_data_rdy      (src_data_rdy),
        .dst_val           (dst_val),
        .dst_data          (dst_data),
        .dst_last          (dst_last),
        .dst_padbytes      (dst_padbytes),
        .dst_rdy           (dst_rdy)
    );

    typedef struct {
        logic [63:0] data;
        logic        last;
        logic [2:0]  pad;
    } exp_t;

    exp_t         exp_q[$];
    int           checks = 0;
    int           failures = 0;
    logic [15:0]  model_id;
    logic         stall_en = 1'b0;
    logic         saw_src_rdy = 1'b0;
    int           pkt_cnt = 0;
    int           rec_words[$];
    int           rec_pad[$];
    logic [15:0]  rec_id[$];
    logic [159:0] rec_iphdr[$];

    task automatic chk(input string nm, input logic [159:0] act, input logic [159:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%0h want=%0h", nm, act, exp);
        end
    endtask

    function automatic logic [15:0] model_chksum(input logic [7:0] b[20]);
        int s = 0;
        for (int i = 0; i < 10; i++)
            if (i != 5) s += int'({b[2*i], b[2*i+1]});
        while ((s >> 16) != 0) s = (s & 32'hFFFF) + (s >> 16);
        return ~s[15:0];
    endfunction

    function automatic logic [7:0] pay_byte(input int seed, input int i);
        return 8'(seed * 37 + i * 5 + 1);
    endfunction

    // Builds the frame byte-by-byte from the header rules and packs it into expected words.
    task automatic push_expected(input int len, input int seed);
        logic [7:0]  fb[$];
        logic [7:0]  ip[20];
        logic [15:0] ck, tot, ulen;
        int          nw, sz, idx;
        exp_t        e;
        fb = {};
        for (int k = 5; k >= 0; k--) fb.push_back(src_meta_dst_mac[8*k +: 8]);
        for (int k = 5; k >= 0; k--) fb.push_back(src_meta_src_mac[8*k +: 8]);
        fb.push_back(8'h08);
        fb.push_back(8'h00);
        tot  = 16'(28 + len);
        ulen = 16'(8 + len);
        ip = '{8'h45, 8'h00, tot[15:8], tot[7:0], model_id[15:8], model_id[7:0],
               8'h40, 8'h00, TTL, 8'd17, 8'h00, 8'h00,
               src_meta_src_ip[31:24], src_meta_src_ip[23:16], src_meta_src_ip[15:8], src_meta_src_ip[7:0],
               src_meta_dst_ip[31:24], src_meta_dst_ip[23:16], src_meta_dst_ip[15:8], src_meta_dst_ip[7:0]};
        ck = model_chksum(ip);
        ip[10] = ck[15:8];
        ip[11] = ck[7:0];
        for (int k = 0; k < 20; k++) fb.push_back(ip[k]);
        fb.push_back(src_meta_src_port[15:8]); fb.push_back(src_meta_src_port[7:0]);
        fb.push_back(src_meta_dst_port[15:8]); fb.push_back(src_meta_dst_port[7:0]);
        fb.push_back(ulen[15:8]);              fb.push_back(ulen[7:0]);
        fb.push_back(8'h00);                   fb.push_back(8'h00);
        for (int i = 0; i < len; i++) fb.push_back(pay_byte(seed, i));
        sz = fb.size();
        nw = (sz + 7) / 8;
        for (int w = 0; w < nw; w++) begin
            e.data = '0;
            for (int k = 0; k < 8; k++) begin
                idx = 8 * w + k;
                if (idx < sz) e.data[63-8*k -: 8] = fb[idx];
            end
            e.last = (w == nw - 1);
            e.pad  = e.last ? 3'(nw * 8 - sz) : 3'd0;
            exp_q.push_back(e);
        end
        model_id = model_id + 16'd1;
    endtask

    task automatic meta_hs();
        logic hs;
        int   n = 0;
        src_meta_val = 1'b1;
        forever begin
            @(negedge clk);
            hs = src_meta_rdy;
            @(posedge clk);
            #1;
            if (hs) break;
            n++;
            if (n > 500) begin
                failures++;
                $display("FAIL meta_timeout got=no_rdy want=rdy");
                break;
            end
        end
        src_meta_val = 1'b0;
    endtask

    task automatic send_payload(input int len, input int seed, input int maxw);
        int   nw, idx, n;
        logic hs;
        nw = (len + 7) / 8;
        for (int w = 0; w < nw && w < maxw; w++) begin
            for (int k = 0; k < 8; k++) begin
                idx = 8 * w + k;
                src_data[63-8*k -: 8] = (idx < len) ? pay_byte(seed, idx) : 8'hEE;
            end
            src_data_last     = (w == nw - 1);
            src_data_padbytes = (w == nw - 1) ? 3'(nw * 8 - len) : 3'd0;
            src_data_val      = 1'b1;
            n = 0;
            forever begin
                @(negedge clk);
                hs = src_data_rdy;
                @(posedge clk);
                #1;
                if (hs) break;
                n++;
                if (n > 500) begin
                    failures++;
                    $display("FAIL data_timeout got=no_rdy want=rdy");
                    break;
                end
            end
        end
        src_data_val  = 1'b0;
        src_data_last = 1'b0;
    endtask

    task automatic send_pkt(input int len, input int seed);
        src_meta_data_len = 16'(len);
        push_expected(len, seed);
        meta_hs();
        send_payload(len, seed, 1000);
    endtask

    task automatic wait_pkts(input int n);
        int c = 0;
        while (pkt_cnt < n && c < 3000) begin
            @(posedge clk);
            c++;
        end
        #1;
        chk("pkt_done", 160'(pkt_cnt >= n), 160'(1));
    endtask

    task automatic do_reset();
        rst          = 1'b1;
        src_meta_val = 1'b0;
        src_data_val = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        exp_q.delete();
        model_id = ID_INIT;
    endtask

    initial begin
        dst_rdy = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            dst_rdy = stall_en ? ($urandom_range(0, 3) != 0) : 1'b1;
        end
    end

    // Scoreboard monitor: every accepted output word against the model, plus hold-while-stalled.
    initial begin
        int          cur_words = 0;
        logic        prev_stall = 1'b0;
        logic [63:0] prev_data = '0;
        logic        prev_last = 1'b0;
        logic [2:0]  prev_pad = '0;
        logic [7:0]  hdr_cap[48];
        logic [159:0] v;
        exp_t        e;
        logic        ok;
        forever begin
            @(negedge clk);
            if (rst) begin
                cur_words  = 0;
                prev_stall = 1'b0;
            end else begin
                if (src_data_rdy) saw_src_rdy = 1'b1;
                if (prev_stall) begin
                    checks++;
                    if (!(dst_val && dst_data == prev_data && dst_last == prev_last && dst_padbytes == prev_pad)) begin
                        failures++;
                        $display("FAIL stall_hold got val=%b data=%h want val=1 data=%h", dst_val, dst_data, prev_data);
                    end
                end
                if (dst_val && dst_rdy) begin
                    checks++;
                    if (exp_q.size() == 0) begin
                        failures++;
                        $display("FAIL dst_word got=%h want=no_word", dst_data);
                    end else begin
                        e  = exp_q.pop_front();
                        ok = (dst_last === e.last);
                        if (e.last && dst_padbytes !== e.pad) ok = 1'b0;
                        for (int k = 0; k < 8; k++)
                            if (k < 8 - int'(e.pad) && dst_data[63-8*k -: 8] !== e.data[63-8*k -: 8]) ok = 1'b0;
                        if (!ok) begin
                            failures++;
                            $display("FAIL dst_word pkt=%0d word=%0d got data=%h last=%b pad=%0d want data=%h last=%b pad=%0d",
                                     pkt_cnt, cur_words, dst_data, dst_last, dst_padbytes, e.data, e.last, e.pad);
                        end
                    end
                    if (cur_words < 6)
                        for (int k = 0; k < 8; k++) hdr_cap[8*cur_words+k] = dst_data[63-8*k -: 8];
                    cur_words++;
                    if (dst_last) begin
                        for (int k = 0; k < 20; k++) v[159-8*k -: 8] = hdr_cap[14+k];
                        rec_words.push_back(cur_words);
                        rec_pad.push_back(int'(dst_padbytes));
                        rec_id.push_back({hdr_cap[18], hdr_cap[19]});
                        rec_iphdr.push_back(v);
                        cur_words = 0;
                        pkt_cnt++;
                    end
                end
                prev_stall = dst_val && !dst_rdy;
                prev_data  = dst_data;
                prev_last  = dst_last;
                prev_pad   = dst_padbytes;
            end
        end
    end

    initial begin
        logic [7:0] t1b[20];
        rst               = 1'b1;
        src_meta_val      = 1'b0;
        src_data_val      = 1'b0;
        src_data          = '0;
        src_data_last     = 1'b0;
        src_data_padbytes = '0;
        src_meta_src_mac  = 48'h02_00_00_00_00_01;
        src_meta_dst_mac  = 48'hA4_B1_C2_D3_E4_F5;
        src_meta_src_ip   = 32'hC0A8_0001;
        src_meta_dst_ip   = 32'hC0A8_00C7;
        src_meta_src_port = 16'd5000;
        src_meta_dst_port = 16'd6000;
        src_meta_data_len = 16'd0;
        model_id          = ID_INIT;

        @(negedge clk);
        chk("rst_meta_rdy", 160'(src_meta_rdy), 160'(0));
        chk("rst_dst_val",  160'({dst_val, dst_last, dst_padbytes, src_data_rdy}), 160'(0));
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("idle_meta_rdy", 160'(src_meta_rdy), 160'(1));
        @(posedge clk);
        #1;

        t1b = '{8'h45, 8'h00, 8'h00, 8'h73, 8'h00, 8'h00, 8'h40, 8'h00, 8'h40, 8'h11,
                8'h00, 8'h00, 8'hC0, 8'hA8, 8'h00, 8'h01, 8'hC0, 8'hA8, 8'h00, 8'hC7};
        chk("model_chksum_pin", 160'(model_chksum(t1b)), 160'(16'hB861));

        send_pkt(87, 1);
        wait_pkts(1);
        chk("t1_ip_hdr", rec_iphdr[0], 160'h4500_0073_0000_4000_4011_B861_C0A8_0001_C0A8_00C7);

        src_meta_src_ip = 32'h0A00_0001;
        src_meta_dst_ip = 32'h0A00_0102;
        send_pkt(6, 2);
        wait_pkts(2);
        chk("t2_words", 160'(rec_words[1]), 160'(6));
        chk("t2_pad",   160'(rec_pad[1]),   160'(0));

        send_pkt(8, 3);
        wait_pkts(3);
        chk("t3_words", 160'(rec_words[2]), 160'(7));
        chk("t3_pad",   160'(rec_pad[2]),   160'(6));
        chk("t3_bytes", 160'(rec_words[2] * 8 - rec_pad[2]), 160'(50));

        saw_src_rdy = 1'b0;
        send_pkt(0, 4);
        wait_pkts(4);
        chk("t4_words",  160'(rec_words[3]), 160'(6));
        chk("t4_pad",    160'(rec_pad[3]),   160'(6));
        chk("t4_no_rdy", 160'(saw_src_rdy),  160'(0));
        chk("t4_id",     160'(rec_id[3]),    160'(3));

        do_reset();
        stall_en = 1'b1;
        send_pkt(13, 5);
        send_pkt(22, 6);
        send_pkt(47, 7);
        wait_pkts(7);
        stall_en = 1'b0;
        chk("t5_id0", 160'(rec_id[4]), 160'(0));
        chk("t5_id1", 160'(rec_id[5]), 160'(1));
        chk("t5_id2", 160'(rec_id[6]), 160'(2));
        chk("t5_pad2", 160'(rec_pad[6]), 160'(7));

        src_meta_data_len = 16'd40;
        push_expected(40, 8);
        meta_hs();
        send_payload(40, 8, 2);
        rst = 1'b1;
        exp_q.delete();
        model_id = ID_INIT;
        @(negedge clk);
        chk("t6_rst_cycle", 160'({dst_val, src_meta_rdy}), 160'(0));
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("t6_after_rst", 160'({dst_val, src_meta_rdy}), 160'(1));
        chk("t6_no_frame",  160'(pkt_cnt), 160'(7));
        @(posedge clk);
        #1;
        send_pkt(16, 9);
        wait_pkts(8);
        chk("t6_id_reinit", 160'(rec_id[7]), 160'(ID_INIT));
        chk("t6_words",     160'(rec_words[7]), 160'(8));

        repeat (5) @(posedge clk);
        #1;
        chk("exp_q_empty", 160'(exp_q.size()), 160'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
